game_event_scorer: RTL and testbench

- Parametrised successor to the current audio/score sequencing logic in the game controller.
- On each physics step strobe, it arbitrates N prioritised hit events plus ball-lost into a one-cycle audio trigger with sample index.
- It accumulates per-event points into a saturating pending counter, which drains one point per idle clock into a DIGITS-wide BCD score.
- It also owns lives, extra-life awards, game-over and new-game restart.

---
 rtl/game_event_scorer_if.sv | 33 +++
 rtl/game_event_scorer.sv | 178 +++++++++++++++++
 tb/tb_game_event_scorer.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/game_event_scorer_if.sv
// Bundle of the step/event inputs and the audio/score/lives outputs exchanged
// between the game controller and the scorer.
interface game_event_scorer_if #(
    parameter int NUM_EVENTS  = 4,
    parameter int POINT_BITS  = 4,
    parameter int SAMPLE_BITS = 4,
    parameter int LIVES_BITS  = 3,
    parameter int DIGITS      = 3
);
    logic                             STEP_COMPLETE;
    logic [NUM_EVENTS-1:0]            EVENT_VALID;
    logic [NUM_EVENTS*POINT_BITS-1:0] EVENT_POINTS;
    logic                             BALL_LOST;
    logic                             NEW_GAME;
    logic [SAMPLE_BITS-1:0]           AUDIO_SELECT;
    logic                             AUDIO_TRIGGER;
    logic [LIVES_BITS-1:0]            LIVES;
    logic                             GAME_OVER;
    logic [4*DIGITS-1:0]              SCORE_BCD;
    logic                             COUNT_BUSY;

    // Game controller side: produces steps, consumes audio and score state.
    modport master (
        output STEP_COMPLETE, EVENT_VALID, EVENT_POINTS, BALL_LOST, NEW_GAME,
        input  AUDIO_SELECT, AUDIO_TRIGGER, LIVES, GAME_OVER, SCORE_BCD, COUNT_BUSY
    );

    // Scorer side.
    modport slave (
        input  STEP_COMPLETE, EVENT_VALID, EVENT_POINTS, BALL_LOST, NEW_GAME,
        output AUDIO_SELECT, AUDIO_TRIGGER, LIVES, GAME_OVER, SCORE_BCD, COUNT_BUSY
    );
endinterface

// File: rtl/game_event_scorer.sv
// Game event scorer: arbitrates hit / ball-lost events on each physics step
// into an audio trigger, accumulates points into a saturating pending counter
// that drains one point per idle clock into a BCD score, and tracks lives,
// extra-life awards, game-over and new-game restart.
module game_event_scorer #(
    parameter int NUM_EVENTS       = 4,
    parameter int POINT_BITS       = 4,
    parameter int PENDING_BITS     = 6,
    parameter int DIGITS           = 3,
    parameter int SATURATE         = 1,
    parameter int SAMPLE_BITS      = 4,
    parameter int SAMPLE_BASE      = 1,
    parameter int SAMPLE_LOST      = 0,
    parameter int LIVES_BITS       = 3,
    parameter int START_LIVES      = 3,
    parameter int MAX_LIVES        = 7,
    parameter int EXTRA_LIFE_DIGIT = 2
) (
    input logic                CLK,
    input logic                RESET_N,
    game_event_scorer_if.slave bus
);

    localparam int SUM_BITS   = POINT_BITS + $clog2(NUM_EVENTS);
    localparam int ACC_W      = ((PENDING_BITS > SUM_BITS) ? PENDING_BITS : SUM_BITS) + 1;
    localparam int SCORE_BITS = 4 * DIGITS;
    // An out-of-range award digit disables awards; the index is clamped so the
    // carry vector is never addressed out of range.
    localparam bit ELD_EN     = (EXTRA_LIFE_DIGIT < DIGITS);
    localparam int ELD_IDX    = ELD_EN ? EXTRA_LIFE_DIGIT : 0;

    localparam logic [PENDING_BITS-1:0] PEND_MAX   = '1;
    localparam logic [LIVES_BITS-1:0]   LIVES_MAX  = LIVES_BITS'(MAX_LIVES);
    localparam logic [LIVES_BITS-1:0]   LIVES_INIT = LIVES_BITS'(START_LIVES);

    typedef struct packed {
        logic [SCORE_BITS-1:0] score;
        logic [DIGITS-1:0]     carry;   // carry[d] = carry out of digit d
    } bcd_inc_t;

    // Pending counter add, clamped at the all-ones value.
    function automatic logic [PENDING_BITS-1:0] sat_add_pending(
        input logic [PENDING_BITS-1:0] a,
        input logic [SUM_BITS-1:0]     b
    );
        logic [ACC_W-1:0] s;
        s = ACC_W'(a) + ACC_W'(b);
        if (s > ACC_W'(PEND_MAX))
            return PEND_MAX;
        return s[PENDING_BITS-1:0];
    endfunction

    // Ripple +1 through the BCD digits, reporting the carry out of every digit.
    function automatic bcd_inc_t bcd_inc(input logic [SCORE_BITS-1:0] s);
        bcd_inc_t   r;
        logic       c;
        logic [3:0] dig;
        r = '0;
        c = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            dig = s[4*d +: 4];
            if (c && dig == 4'd9) begin
                r.score[4*d +: 4] = 4'd0;
                c = 1'b1;
            end else if (c) begin
                r.score[4*d +: 4] = dig + 4'd1;
                c = 1'b0;
            end else begin
                r.score[4*d +: 4] = dig;
            end
            r.carry[d] = c;
        end
        return r;
    endfunction

    // Lives update: award clamps at the ceiling, loss clamps at zero, and a
    // simultaneous award and loss cancel out.
    function automatic logic [LIVES_BITS-1:0] lives_update(
        input logic [LIVES_BITS-1:0] l,
        input logic                  inc,
        input logic                  dec
    );
        logic [LIVES_BITS-1:0] r;
        r = l;
        if (inc && !dec) begin
            if (l < LIVES_MAX)
                r = l + LIVES_BITS'(1);
        end else if (dec && !inc) begin
            if (l != '0)
                r = l - LIVES_BITS'(1);
        end
        return r;
    endfunction

    logic [PENDING_BITS-1:0] pending_q;
    logic [SCORE_BITS-1:0]   score_q;
    logic [LIVES_BITS-1:0]   lives_q;
    logic                    game_over_q;
    logic [SAMPLE_BITS-1:0]  aud_sel_p1;
    logic                    vld_p1;

    logic                    step_ok;
    logic                    drain;
    logic                    win_any;
    logic [SAMPLE_BITS-1:0]  win_sel;
    logic [SUM_BITS-1:0]     hit_sum;
    bcd_inc_t                inc_r;
    logic                    sat_hold;
    logic [SCORE_BITS-1:0]   score_inc;
    logic                    award;
    logic [LIVES_BITS-1:0]   lives_d;

    // Step arbitration, point summation, drain increment and lives next-state.
    always_comb begin
        step_ok = bus.STEP_COMPLETE && !game_over_q && !bus.NEW_GAME;
        drain   = !bus.STEP_COMPLETE && (pending_q != '0);

        win_any = bus.BALL_LOST || (|bus.EVENT_VALID);
        win_sel = SAMPLE_BITS'(SAMPLE_LOST);
        if (!bus.BALL_LOST) begin
            for (int i = NUM_EVENTS - 1; i >= 0; i--) begin
                if (bus.EVENT_VALID[i])
                    win_sel = SAMPLE_BITS'(SAMPLE_BASE + i);
            end
        end

        hit_sum = '0;
        for (int i = 0; i < NUM_EVENTS; i++) begin
            if (bus.EVENT_VALID[i])
                hit_sum = hit_sum + SUM_BITS'(bus.EVENT_POINTS[i*POINT_BITS +: POINT_BITS]);
        end

        inc_r     = bcd_inc(score_q);
        sat_hold  = (SATURATE != 0) && inc_r.carry[DIGITS-1];
        score_inc = sat_hold ? score_q : inc_r.score;
        award     = drain && !sat_hold && ELD_EN && inc_r.carry[ELD_IDX];

        lives_d   = lives_update(lives_q, award, step_ok && bus.BALL_LOST);
    end

    // ---- stage p1: registered audio, pending, score and lives state ----
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pending_q   <= '0;
            score_q     <= '0;
            lives_q     <= LIVES_INIT;
            game_over_q <= 1'b0;
            aud_sel_p1  <= '0;
            vld_p1      <= 1'b0;
        end else if (bus.NEW_GAME) begin
            pending_q   <= '0;
            score_q     <= '0;
            lives_q     <= LIVES_INIT;
            game_over_q <= 1'b0;
            vld_p1      <= 1'b0;
        end else begin
            vld_p1 <= step_ok && win_any;
            if (step_ok && win_any)
                aud_sel_p1 <= win_sel;
            if (step_ok && !bus.BALL_LOST) begin
                pending_q <= sat_add_pending(pending_q, hit_sum);
            end else if (drain) begin
                pending_q <= pending_q - PENDING_BITS'(1);
                score_q   <= score_inc;
            end
            lives_q     <= lives_d;
            game_over_q <= (lives_d == '0);
        end
    end

    assign bus.AUDIO_SELECT  = aud_sel_p1;
    assign bus.AUDIO_TRIGGER = vld_p1;
    assign bus.LIVES         = lives_q;
    assign bus.GAME_OVER     = game_over_q;
    assign bus.SCORE_BCD     = score_q;
    assign bus.COUNT_BUSY    = (pending_q != '0);

endmodule

// File: tb/tb_game_event_scorer.sv
// Bench for game_event_scorer: three instances (saturating default, wrapping,
// hundreds-digit... tens-carry award) share one stimulus stream; audio
// triggers of the default instance are scoreboarded against a queue.
module tb_game_event_scorer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        step = 1'b0;
    logic [3:0]  ev_valid = '0;
    logic [15:0] ev_points = '0;
    logic        ball_lost = 1'b0;
    logic        new_game = 1'b0;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [3:0]  exp_audio[$];
    logic [3:0]  mon_exp;
    int          exp_score = 0;

    always #5 clk = ~clk;

    game_event_scorer_if if_a ();
    game_event_scorer_if if_b ();
    game_event_scorer_if if_c ();

    assign if_a.STEP_COMPLETE = step;
    assign if_a.EVENT_VALID   = ev_valid;
    assign if_a.EVENT_POINTS  = ev_points;
    assign if_a.BALL_LOST     = ball_lost;
    assign if_a.NEW_GAME      = new_game;
    assign if_b.STEP_COMPLETE = step;
    assign if_b.EVENT_VALID   = ev_valid;
    assign if_b.EVENT_POINTS  = ev_points;
    assign if_b.BALL_LOST     = ball_lost;
    assign if_b.NEW_GAME      = new_game;
    assign if_c.STEP_COMPLETE = step;
    assign if_c.EVENT_VALID   = ev_valid;
    assign if_c.EVENT_POINTS  = ev_points;
    assign if_c.BALL_LOST     = ball_lost;
    assign if_c.NEW_GAME      = new_game;

    game_event_scorer #(.SATURATE(1), .EXTRA_LIFE_DIGIT(2)) dut_a (.CLK(clk), .RESET_N(rst_n), .bus(if_a));
    game_event_scorer #(.SATURATE(0), .EXTRA_LIFE_DIGIT(2)) dut_b (.CLK(clk), .RESET_N(rst_n), .bus(if_b));
    game_event_scorer #(.SATURATE(1), .EXTRA_LIFE_DIGIT(1)) dut_c (.CLK(clk), .RESET_N(rst_n), .bus(if_c));

    function automatic logic [11:0] to_bcd(input int v);
        return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Every trigger of instance A must match the oldest expected sample.
    always @(negedge clk) begin
        if (if_a.AUDIO_TRIGGER !== 1'b0) begin
            n_cmp++;
            if (exp_audio.size() == 0) begin
                n_fail++;
                $display("FAIL audio_unexpected: trigger=%b select=%0d, no trigger expected",
                         if_a.AUDIO_TRIGGER, if_a.AUDIO_SELECT);
            end else begin
                mon_exp = exp_audio.pop_front();
                if (if_a.AUDIO_SELECT !== mon_exp) begin
                    n_fail++;
                    $display("FAIL audio_select: got %0d expected %0d", if_a.AUDIO_SELECT, mon_exp);
                end
            end
        end
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_step(input logic [3:0] v, input logic [15:0] p, input logic bl, input logic ng);
        step = 1'b1; ev_valid = v; ev_points = p; ball_lost = bl; new_game = ng;
        @(posedge clk);
        #1;
        step = 1'b0; ev_valid = '0; ev_points = '0; ball_lost = 1'b0; new_game = 1'b0;
    endtask

    // Feeds n points in steps of at most 60 and waits for each to drain.
    task automatic add_points(input int n);
        int          rem;
        int          chunk;
        int          part;
        logic [3:0]  v;
        logic [15:0] p;
        rem = n;
        while (rem > 0) begin
            chunk = (rem > 60) ? 60 : rem;
            part = chunk;
            v = '0;
            p = '0;
            for (int i = 0; i < 4; i++) begin
                if (part > 0) begin
                    v[i] = 1'b1;
                    p[i*4 +: 4] = 4'((part > 15) ? 15 : part);
                    part = part - ((part > 15) ? 15 : part);
                end
            end
            exp_audio.push_back(4'd1);
            do_step(v, p, 1'b0, 1'b0);
            idle(chunk + 1);
            rem = rem - chunk;
            exp_score = exp_score + chunk;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (if_a.AUDIO_TRIGGER !== 1'b0 || if_a.AUDIO_SELECT !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_audio: trig=%b sel=%0d expected 0/0", if_a.AUDIO_TRIGGER, if_a.AUDIO_SELECT);
        end
        n_cmp++;
        if (if_a.LIVES !== 3'd3 || if_a.GAME_OVER !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_lives: lives=%0d go=%b expected 3/0", if_a.LIVES, if_a.GAME_OVER);
        end
        n_cmp++;
        if (if_a.SCORE_BCD !== 12'h000 || if_a.COUNT_BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_score: score=%h busy=%b expected 000/0", if_a.SCORE_BCD, if_a.COUNT_BUSY);
        end
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_hit_audio;
        int busy_cnt;
        exp_audio.push_back(4'd3);
        do_step(4'b0100, 16'h0300, 1'b0, 1'b0);
        n_cmp++;
        if (if_a.AUDIO_TRIGGER !== 1'b1) begin
            n_fail++;
            $display("FAIL hit_trigger: got %b expected 1", if_a.AUDIO_TRIGGER);
        end
        busy_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            if (if_a.COUNT_BUSY === 1'b1) busy_cnt++;
            idle(1);
        end
        n_cmp++;
        if (busy_cnt != 3) begin
            n_fail++;
            $display("FAIL hit_busy_cycles: got %0d expected 3", busy_cnt);
        end
        n_cmp++;
        if (if_a.SCORE_BCD !== 12'h003) begin
            n_fail++;
            $display("FAIL hit_score: got %h expected 003", if_a.SCORE_BCD);
        end
        do_step(4'b0000, 16'h0000, 1'b0, 1'b0);
        n_cmp++;
        if (if_a.AUDIO_TRIGGER !== 1'b0 || if_a.AUDIO_SELECT !== 4'd3) begin
            n_fail++;
            $display("FAIL empty_step: trig=%b sel=%0d expected 0/3", if_a.AUDIO_TRIGGER, if_a.AUDIO_SELECT);
        end
        exp_score = 3;
    endtask

    task automatic test_ball_lost;
        exp_audio.push_back(4'd0);
        do_step(4'b0001, 16'h0005, 1'b1, 1'b0);
        n_cmp++;
        if (if_a.LIVES !== 3'd2) begin
            n_fail++;
            $display("FAIL lost_lives: got %0d expected 2", if_a.LIVES);
        end
        idle(3);
        n_cmp++;
        if (if_a.SCORE_BCD !== to_bcd(exp_score) || if_a.COUNT_BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL lost_score: score=%h busy=%b expected %h/0", if_a.SCORE_BCD, if_a.COUNT_BUSY, to_bcd(exp_score));
        end
    endtask

    task automatic test_back_to_back;
        int busy_cnt;
        exp_audio.push_back(4'd1);
        exp_audio.push_back(4'd1);
        do_step(4'hF, 16'hFFFF, 1'b0, 1'b0);
        do_step(4'hF, 16'hFFFF, 1'b0, 1'b0);
        busy_cnt = 0;
        for (int k = 0; k < 70; k++) begin
            if (if_a.COUNT_BUSY === 1'b1) busy_cnt++;
            idle(1);
        end
        n_cmp++;
        if (busy_cnt != 63) begin
            n_fail++;
            $display("FAIL pending_saturate: drained %0d expected 63", busy_cnt);
        end
        exp_score = exp_score + 63;
        n_cmp++;
        if (if_a.SCORE_BCD !== to_bcd(exp_score)) begin
            n_fail++;
            $display("FAIL b2b_score: got %h expected %h", if_a.SCORE_BCD, to_bcd(exp_score));
        end
    endtask

    task automatic test_extra_life;
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        exp_score = 0;
        add_points(95);
        n_cmp++;
        if (if_c.SCORE_BCD !== 12'h095 || if_c.LIVES !== 3'd3) begin
            n_fail++;
            $display("FAIL c_pre_award: score=%h lives=%0d expected 095/3", if_c.SCORE_BCD, if_c.LIVES);
        end
        exp_audio.push_back(4'd1);
        do_step(4'b0001, 16'h000A, 1'b0, 1'b0);
        for (int k = 0; k < 12; k++) begin
            if (if_c.SCORE_BCD === 12'h099) begin
                n_cmp++;
                if (if_c.LIVES !== 3'd3) begin
                    n_fail++;
                    $display("FAIL c_lives_at_099: got %0d expected 3", if_c.LIVES);
                end
            end
            if (if_c.SCORE_BCD === 12'h100) begin
                n_cmp++;
                if (if_c.LIVES !== 3'd4) begin
                    n_fail++;
                    $display("FAIL c_lives_at_100: got %0d expected 4", if_c.LIVES);
                end
            end
            idle(1);
        end
        exp_score = exp_score + 10;
        n_cmp++;
        if (if_a.LIVES !== 3'd3 || if_a.SCORE_BCD !== to_bcd(exp_score)) begin
            n_fail++;
            $display("FAIL a_no_award: lives=%0d score=%h expected 3/%h", if_a.LIVES, if_a.SCORE_BCD, to_bcd(exp_score));
        end
        add_points(300);
        n_cmp++;
        if (if_c.LIVES !== 3'd7) begin
            n_fail++;
            $display("FAIL c_lives_405: got %0d expected 7", if_c.LIVES);
        end
        add_points(100);
        n_cmp++;
        if (if_c.LIVES !== 3'd7 || if_c.SCORE_BCD !== to_bcd(exp_score)) begin
            n_fail++;
            $display("FAIL c_lives_clamp: lives=%0d score=%h expected 7/%h", if_c.LIVES, if_c.SCORE_BCD, to_bcd(exp_score));
        end
    endtask

    task automatic test_score_wrap;
        add_points(998 - exp_score);
        n_cmp++;
        if (if_a.SCORE_BCD !== 12'h998) begin
            n_fail++;
            $display("FAIL score_998: got %h expected 998", if_a.SCORE_BCD);
        end
        exp_audio.push_back(4'd1);
        do_step(4'b0001, 16'h0005, 1'b0, 1'b0);
        idle(7);
        n_cmp++;
        if (if_a.SCORE_BCD !== 12'h999 || if_a.LIVES !== 3'd3 || if_a.COUNT_BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_hold: score=%h lives=%0d busy=%b expected 999/3/0", if_a.SCORE_BCD, if_a.LIVES, if_a.COUNT_BUSY);
        end
        n_cmp++;
        if (if_b.SCORE_BCD !== 12'h003 || if_b.LIVES !== 3'd4) begin
            n_fail++;
            $display("FAIL wrap: score=%h lives=%0d expected 003/4", if_b.SCORE_BCD, if_b.LIVES);
        end
    endtask

    task automatic test_game_over;
        for (int i = 0; i < 3; i++) begin
            exp_audio.push_back(4'd0);
            do_step(4'b0000, 16'h0000, 1'b1, 1'b0);
            n_cmp++;
            if (if_a.LIVES !== 3'(2 - i) || if_a.GAME_OVER !== (i == 2)) begin
                n_fail++;
                $display("FAIL lose_%0d: lives=%0d go=%b expected %0d/%b", i, if_a.LIVES, if_a.GAME_OVER, 2 - i, (i == 2));
            end
        end
        do_step(4'b0001, 16'h0005, 1'b0, 1'b0);
        idle(3);
        n_cmp++;
        if (if_a.SCORE_BCD !== 12'h999 || if_a.COUNT_BUSY !== 1'b0 || if_a.LIVES !== 3'd0) begin
            n_fail++;
            $display("FAIL go_ignore: score=%h busy=%b lives=%0d expected 999/0/0", if_a.SCORE_BCD, if_a.COUNT_BUSY, if_a.LIVES);
        end
        do_step(4'b0001, 16'h0005, 1'b0, 1'b1);
        n_cmp++;
        if (if_a.LIVES !== 3'd3 || if_a.GAME_OVER !== 1'b0 || if_a.SCORE_BCD !== 12'h000 || if_a.AUDIO_TRIGGER !== 1'b0) begin
            n_fail++;
            $display("FAIL new_game_a: lives=%0d go=%b score=%h trig=%b expected 3/0/000/0",
                     if_a.LIVES, if_a.GAME_OVER, if_a.SCORE_BCD, if_a.AUDIO_TRIGGER);
        end
        n_cmp++;
        if (if_b.AUDIO_TRIGGER !== 1'b0 || if_b.COUNT_BUSY !== 1'b0 || if_b.SCORE_BCD !== 12'h000 || if_b.LIVES !== 3'd3) begin
            n_fail++;
            $display("FAIL new_game_override: trig=%b busy=%b score=%h lives=%0d expected 0/0/000/3",
                     if_b.AUDIO_TRIGGER, if_b.COUNT_BUSY, if_b.SCORE_BCD, if_b.LIVES);
        end
    endtask

    task automatic test_reset_mid_drain;
        exp_audio.push_back(4'd1);
        do_step(4'hF, 16'hFFFF, 1'b0, 1'b0);
        idle(10);
        n_cmp++;
        if (if_a.SCORE_BCD !== 12'h010 || if_a.COUNT_BUSY !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_drain: score=%h busy=%b expected 010/1", if_a.SCORE_BCD, if_a.COUNT_BUSY);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (if_a.SCORE_BCD !== 12'h000 || if_a.COUNT_BUSY !== 1'b0 || if_a.AUDIO_SELECT !== 4'd0 ||
            if_a.AUDIO_TRIGGER !== 1'b0 || if_a.LIVES !== 3'd3 || if_a.GAME_OVER !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: score=%h busy=%b sel=%0d trig=%b lives=%0d go=%b expected 000/0/0/0/3/0",
                     if_a.SCORE_BCD, if_a.COUNT_BUSY, if_a.AUDIO_SELECT, if_a.AUDIO_TRIGGER, if_a.LIVES, if_a.GAME_OVER);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(3);
        n_cmp++;
        if (if_a.SCORE_BCD !== 12'h000 || if_a.COUNT_BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset: score=%h busy=%b expected 000/0", if_a.SCORE_BCD, if_a.COUNT_BUSY);
        end
    endtask

    initial begin
        test_reset();
        test_hit_audio();
        test_ball_lost();
        test_back_to_back();
        test_extra_life();
        test_score_wrap();
        test_game_over();
        test_reset_mid_drain();
        n_cmp++;
        if (exp_audio.size() != 0) begin
            n_fail++;
            $display("FAIL audio_missing: %0d expected triggers never seen, required 0", exp_audio.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
